wb_stage: RTL

//  Writeback stage; consumes the registered MEM-stage outputs (instruction, ALU result, load data).

---
 rtl/riscv_cpu_pkg.sv | 35 +++
 rtl/wb_stage_if.sv | 39 +++
 rtl/wb_stage_register_file.sv | 43 ++++
 rtl/wb_stage.sv | 114 +++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// Shared CPU definitions: datapath width, major opcodes, writeback source and load encodings.
package riscv_cpu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned INSTRET_W  = 64;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2,
    WB_PC4  = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } load_type_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB payload, decode read ports and forwarding/retire outputs of the writeback stage.
// instret_o exists only when WB_INSTRET_EN is defined.
interface wb_stage_if;
  import riscv_cpu_pkg::*;

  logic                   valid_i;
  logic [INSTR_W-1:0]     instr_rdata_i;
  logic [31:0]            pc_wb_i;
  logic [DATA_WIDTH-1:0]  alu_result_i;
  logic [DATA_WIDTH-1:0]  mem_data_i;
  logic [REG_ADDR_W-1:0]  raddr_a_i;
  logic [REG_ADDR_W-1:0]  raddr_b_i;
  logic [DATA_WIDTH-1:0]  rdata_a_o;
  logic [DATA_WIDTH-1:0]  rdata_b_o;
  logic                   rf_we_o;
  logic [REG_ADDR_W-1:0]  rf_waddr_o;
  logic [DATA_WIDTH-1:0]  rf_wdata_o;
  logic                   retired_o;
`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0]   instret_o;
`endif

  modport master (
    output valid_i, instr_rdata_i, pc_wb_i, alu_result_i, mem_data_i, raddr_a_i, raddr_b_i,
    input  rdata_a_o, rdata_b_o, rf_we_o, rf_waddr_o, rf_wdata_o, retired_o
`ifdef WB_INSTRET_EN
    , input instret_o
`endif
  );

  modport slave (
    input  valid_i, instr_rdata_i, pc_wb_i, alu_result_i, mem_data_i, raddr_a_i, raddr_b_i,
    output rdata_a_o, rdata_b_o, rf_we_o, rf_waddr_o, rf_wdata_o, retired_o
`ifdef WB_INSTRET_EN
    , output instret_o
`endif
  );

endinterface

// File: rtl/wb_stage_register_file.sv
// Integer register file: x1..x(NUM_REGS-1) flops, x0 reads zero, two combinational
// read ports with write-through bypass so a WB write is visible to decode the same cycle.
module register_file_2r1w #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [4:0]            raddr_a,
  input  logic [4:0]            raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS-1:1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read A: x0 first, then bypass, then array
  always_comb begin
    rdata_a = '0;
    if (raddr_a == 5'd0)                rdata_a = '0;
    else if (we && (raddr_a == waddr))  rdata_a = wdata;
    else                                rdata_a = regs[raddr_a];
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b == 5'd0)                rdata_b = '0;
    else if (we && (raddr_b == waddr))  rdata_b = wdata;
    else                                rdata_b = regs[raddr_b];
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: decodes rd and result source, aligns load data, writes the register file
// and reports retirement. Define WB_INSTRET_EN to add the 64-bit retired-instruction counter.
module wb_stage
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input logic       clk_i,
  input logic       rst_ni,
  wb_stage_if.slave wb
);

  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [2:0]            funct3;
  logic [1:0]            off;
  wb_sel_e               sel;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  legal_load;
  logic                  load_ok;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic                  retired;
  logic                  unused_instr_bits;

  assign opcode = wb.instr_rdata_i[6:0];
  assign rd     = wb.instr_rdata_i[11:7];
  assign funct3 = wb.instr_rdata_i[14:12];
  assign off    = wb.alu_result_i[1:0];
  assign unused_instr_bits = ^wb.instr_rdata_i[INSTR_W-1:15];

  always_comb begin
    sel = WB_NONE;
    case (opcode)
      OPCODE_LOAD:                                  sel = WB_LOAD;
      OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI,
      OPCODE_AUIPC, OPCODE_SYSTEM:                  sel = WB_ALU;
      OPCODE_JAL, OPCODE_JALR:                      sel = WB_PC4;
      default:                                      sel = WB_NONE;
    endcase
  end

  // Misaligned halves use off[1] only; LW ignores the offset entirely
  always_comb begin
    byte_lane = wb.mem_data_i[7:0];
    case (off)
      2'd0:    byte_lane = wb.mem_data_i[7:0];
      2'd1:    byte_lane = wb.mem_data_i[15:8];
      2'd2:    byte_lane = wb.mem_data_i[23:16];
      default: byte_lane = wb.mem_data_i[31:24];
    endcase
    half_lane = off[1] ? wb.mem_data_i[31:16] : wb.mem_data_i[15:0];
  end

  always_comb begin
    load_data  = '0;
    legal_load = 1'b1;
    case (load_type_e'(funct3))
      LOAD_LB:  load_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      LOAD_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      LOAD_LH:  load_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      LOAD_LHU: load_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      LOAD_LW:  load_data = wb.mem_data_i;
      default:  legal_load = 1'b0;
    endcase
  end

  always_comb begin
    wdata = wb.alu_result_i;
    case (sel)
      WB_LOAD: wdata = load_data;
      WB_PC4:  wdata = DATA_WIDTH'(wb.pc_wb_i + 32'd4);
      default: wdata = wb.alu_result_i;
    endcase
  end

  assign load_ok = (sel != WB_LOAD) || legal_load;
  assign we      = rst_ni && wb.valid_i && (sel != WB_NONE) && (rd != 5'd0) && load_ok;
  assign retired = rst_ni && wb.valid_i;

  assign wb.rf_we_o    = we;
  assign wb.rf_waddr_o = rd;
  assign wb.rf_wdata_o = wdata;
  assign wb.retired_o  = retired;

  register_file_2r1w #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we      (we),
    .waddr   (rd),
    .wdata   (wdata),
    .raddr_a (wb.raddr_a_i),
    .raddr_b (wb.raddr_b_i),
    .rdata_a (wb.rdata_a_o),
    .rdata_b (wb.rdata_b_o)
  );

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      instret_q <= '0;
    else if (retired) instret_q <= instret_q + INSTRET_W'(1);
  end

  assign wb.instret_o = instret_q;
`endif

endmodule
